pipe_run_ctrl: RTL

//  Run-control sequencer for the 5-stage pipeline datapath: owns the instruction counter (PC).

---
 rtl/pipe_ctrl_pkg.sv | 52 +++++
 rtl/pipe_run_ctrl_if.sv | 13 +
 rtl/pipe_cmd_strobe.sv | 54 +++++
 rtl/pipe_run_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline run-control block.
//   run_state_e  : sequencer states, values are reported in status[2:0]
//   cmd_op_e     : host command opcodes carried in cmd_word[18:16]
//   halt_cause_e : halt cause reported in status[5:4]
//   HALT_INST_DEF: default fetched word that ends a program
//   cmd_accepted : which opcodes each state takes
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5
  } run_state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_RUN   = 3'd2,
    OP_STEP  = 3'd3,
    OP_HALT  = 3'd4,
    OP_SETPC = 3'd5,
    OP_ILL6  = 3'd6,
    OP_ILL7  = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,  // also the breakpoint cause
    CAUSE_INST = 2'd1,
    CAUSE_CMD  = 2'd2,
    CAUSE_STEP = 2'd3
  } halt_cause_e;

  localparam logic [31:0] HALT_INST_DEF = 32'h0000_007F;

  // NOP is harmless everywhere except DRAIN, where every command is an error.
  function automatic logic cmd_accepted(input run_state_e st, input cmd_op_e op);
    logic ok;
    ok = 1'b0;
    case (st)
      ST_IDLE, ST_HALTED: ok = op inside {OP_NOP, OP_LOAD, OP_RUN, OP_STEP, OP_SETPC};
      ST_LOAD:            ok = op inside {OP_NOP, OP_RUN, OP_SETPC, OP_HALT};
      ST_RUN:             ok = op inside {OP_NOP, OP_HALT};
      ST_STEP:            ok = (op == OP_NOP);
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/pipe_run_ctrl_if.sv
// pipe_run_ctrl_if: host register bundle between generic_regs and pipe_run_ctrl.
//   cmd_word  : SW reg, [31]=toggle strobe, [18:16]=opcode, [PC_W-1:0]=pc arg
//   status    : HW reg, [2:0]=state, [3]=cmd_err, [5:4]=halt cause, [6]=breakpoint hit
//   cycle_cnt : HW reg, cycles spent in RUN/STEP/DRAIN
// master = register block side, slave = run-control side.
interface pipe_run_ctrl_if;
  logic [31:0] cmd_word;
  logic [31:0] status;
  logic [31:0] cycle_cnt;

  modport master (output cmd_word, input status, input cycle_cnt);
  modport slave  (input cmd_word, output status, output cycle_cnt);
endinterface

// File: rtl/pipe_cmd_strobe.sv
// pipe_cmd_strobe: turns a toggle of cmd_word[31] into a one-cycle registered
// command pulse, capturing opcode and pc argument alongside it.
//   clk, reset : clock, asynchronous active-high reset
//   cmd_word   : host command register
//   cmd_fire   : one-cycle pulse, cycle after the toggle was seen
//   cmd_op     : opcode valid with cmd_fire
//   cmd_arg    : pc argument valid with cmd_fire
module pipe_cmd_strobe
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     cmd_word,
  output logic            cmd_fire,
  output cmd_op_e         cmd_op,
  output logic [PC_W-1:0] cmd_arg
);

  logic            strobe_q, strobe_d;
  logic            fire_q, fire_d;
  cmd_op_e         op_q, op_d;
  logic [PC_W-1:0] arg_q, arg_d;
  logic            unused_bits;

  assign unused_bits = ^{cmd_word[30:19], cmd_word[15:PC_W]};

  always_comb begin
    strobe_d = cmd_word[31];
    fire_d   = cmd_word[31] ^ strobe_q;
    op_d     = cmd_op_e'(cmd_word[18:16]);
    arg_d    = cmd_word[PC_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      fire_q   <= 1'b0;
      op_q     <= OP_NOP;
      arg_q    <= '0;
    end else begin
      strobe_q <= strobe_d;
      fire_q   <= fire_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
    end
  end

  assign cmd_fire = fire_q;
  assign cmd_op   = op_q;
  assign cmd_arg  = arg_q;

endmodule

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run-control sequencer for the 5-stage pipeline. Owns the PC,
// loads/runs/steps/halts/drains the pipeline on host commands.
//   clk, reset   : clock, asynchronous active-high reset
//   host         : cmd_word in, status and cycle_cnt out (pipe_run_ctrl_if.slave)
//   fetch_inst   : word currently fetched from imem port A
//   br_taken     : branch resolved taken in MEM, br_target is the new pc
//   pc           : instruction counter, drives imem addra
//   imem_load_en : host owns imem port B
//   pipe_flush   : clears ID/EX, EX/MEM, MEM/WB registers
// Optional macro PIPE_RUN_CTRL_BKPT_EN adds bkpt_addr/bkpt_en: in RUN a next
// pc equal to bkpt_addr stops fetch there and drains (cause 0, status[6]=1).
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned DRAIN_CYC = 4,
  parameter logic [31:0] HALT_INST = HALT_INST_DEF
) (
  input  logic            clk,
  input  logic            reset,
  pipe_run_ctrl_if.slave  host,
  input  logic [31:0]     fetch_inst,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
`ifdef PIPE_RUN_CTRL_BKPT_EN
  input  logic [PC_W-1:0] bkpt_addr,
  input  logic            bkpt_en,
`endif
  output logic [PC_W-1:0] pc,
  output logic            imem_load_en,
  output logic            pipe_flush
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  logic            cmd_fire;
  cmd_op_e         cmd_op;
  logic [PC_W-1:0] cmd_arg;

  pipe_cmd_strobe #(.PC_W(PC_W)) u_strobe (
    .clk      (clk),
    .reset    (reset),
    .cmd_word (host.cmd_word),
    .cmd_fire (cmd_fire),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg)
  );

  run_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             err_q, err_d;
  halt_cause_e      cause_q, cause_d;
  logic             bkpt_q, bkpt_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic             load_en_q, load_en_d;
  logic             flush_q, flush_d;

  logic             acc, halt_inst, enter_run;
  logic [PC_W-1:0]  pc_inc, pc_nxt;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_d     = err_q;
    cause_d   = cause_q;
    bkpt_d    = bkpt_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;

    pc_inc    = (pc_q == '1) ? pc_q : pc_q + 1'b1;
    pc_nxt    = br_taken ? br_target : pc_inc;
    halt_inst = (fetch_inst == HALT_INST);
    acc       = cmd_accepted(state_q, cmd_op);

    if (cmd_fire && !acc) err_d = 1'b1;
    if (state_q inside {ST_RUN, ST_STEP, ST_DRAIN}) cnt_d = cnt_q + 32'd1;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (cmd_fire && acc) begin
          case (cmd_op)
            OP_LOAD:  begin state_d = ST_LOAD; err_d = 1'b0; end
            OP_RUN:   state_d = ST_RUN;
            OP_STEP:  state_d = ST_STEP;
            OP_SETPC: begin pc_d = cmd_arg; cnt_d = '0; end
            default:  ;
          endcase
        end
      end
      ST_LOAD: begin
        if (cmd_fire && acc) begin
          case (cmd_op)
            OP_RUN:   state_d = ST_RUN;
            OP_SETPC: begin state_d = ST_IDLE; pc_d = cmd_arg; cnt_d = '0; end
            OP_HALT:  state_d = ST_IDLE;
            default:  ;
          endcase
        end
      end
      ST_RUN: begin
        // A halt stops fetch at the current pc; a taken branch still wins.
        if (halt_inst || (cmd_fire && acc && cmd_op == OP_HALT)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          pc_d    = br_taken ? br_target : pc_q;
          cause_d = halt_inst ? CAUSE_INST : CAUSE_CMD;
        end else begin
          pc_d = pc_nxt;
`ifdef PIPE_RUN_CTRL_BKPT_EN
          if (bkpt_en && pc_nxt == bkpt_addr) begin
            state_d = ST_DRAIN;
            drain_d = '0;
            cause_d = CAUSE_NONE;
            bkpt_d  = 1'b1;
          end
`endif
        end
      end
      ST_STEP: begin
        pc_d    = pc_nxt;
        state_d = ST_DRAIN;
        drain_d = '0;
        cause_d = CAUSE_STEP;
      end
      ST_DRAIN: begin
        if (br_taken) pc_d = br_target;
        if (drain_q == DRAIN_LAST) state_d = ST_HALTED;
        else                       drain_d = drain_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    enter_run = (state_d inside {ST_RUN, ST_STEP}) && (state_d != state_q);
    if (enter_run) begin
      cause_d = CAUSE_NONE;
      bkpt_d  = 1'b0;
    end

    load_en_d = (state_d == ST_LOAD);
    flush_d   = (state_d inside {ST_IDLE, ST_LOAD}) || enter_run;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      err_q     <= 1'b0;
      cause_q   <= CAUSE_NONE;
      bkpt_q    <= 1'b0;
      cnt_q     <= '0;
      drain_q   <= '0;
      load_en_q <= 1'b0;
      flush_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      cause_q   <= cause_d;
      bkpt_q    <= bkpt_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      load_en_q <= load_en_d;
      flush_q   <= flush_d;
    end
  end

  assign pc             = pc_q;
  assign imem_load_en   = load_en_q;
  assign pipe_flush     = flush_q;
  assign host.status    = {25'd0, bkpt_q, cause_q, err_q, state_q};
  assign host.cycle_cnt = cnt_q;

endmodule
